// File: rtl/vfpu_pkg.sv
// Shared definitions for the vector FPU special-case merge stage.
// Optional feature macro: VFPU_EXC_FLAGS_EN (sticky exception flags and the kind field).
package vfpu_pkg;

  localparam int unsigned RES_W  = 32;
  localparam int unsigned KIND_W = 3;
  localparam int unsigned FLAG_W = 5;

  // Special-case classification from the upstream handler; 7 is reserved and acts as none
  typedef enum logic [KIND_W-1:0] {
    KIND_NONE    = 3'd0,
    KIND_NAN     = 3'd1,
    KIND_INVALID = 3'd2,
    KIND_OVF     = 3'd3,
    KIND_UNF     = 3'd4,
    KIND_ZERO    = 3'd5,
    KIND_INF     = 3'd6,
    KIND_RSVD    = 3'd7
  } spec_kind_e;

  // Sticky flag bit positions within {NV, OF, UF, NX, SN}
  localparam int unsigned FLAG_NV = 4;
  localparam int unsigned FLAG_OF = 3;
  localparam int unsigned FLAG_UF = 2;
  localparam int unsigned FLAG_NX = 1;
  localparam int unsigned FLAG_SN = 0;

  localparam logic [RES_W-1:0] QNAN = 32'h7FC0_0000;

  // One delay-line slot; the kind field only travels when flags are tracked
  typedef struct packed {
    logic             valid;
    logic             mask;
    logic [RES_W-1:0] res;
`ifdef VFPU_EXC_FLAGS_EN
    spec_kind_e       kind;
`endif
  } dline_entry_t;

  // Flag contribution of a special case that overrode the datapath
  function automatic logic [FLAG_W-1:0] kind_flags(input spec_kind_e kind);
    logic [FLAG_W-1:0] f;
    f = '0;
    case (kind)
      KIND_NAN: begin
        f[FLAG_SN] = 1'b1;
        f[FLAG_NV] = 1'b1;
      end
      KIND_INVALID: f[FLAG_NV] = 1'b1;
      KIND_OVF: begin
        f[FLAG_OF] = 1'b1;
        f[FLAG_NX] = 1'b1;
      end
      KIND_UNF: f[FLAG_UF] = 1'b1;
      default:  f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/vfpu_spec_dline.sv
// LAT-deep delay line for special-case decisions, advancing in lockstep with the FMA datapath.
// Optional feature macro: VFPU_EXC_FLAGS_EN (entries carry the kind field).
module vfpu_spec_dline
  import vfpu_pkg::*;
#(
  parameter int unsigned LAT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  dline_entry_t din,
  output dline_entry_t tail
);

  dline_entry_t q [LAT];

  // Shift on enable; a clear kills every valid bit but leaves the data fields alone
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        q[i] <= '0;
      end
    end else begin
      if (en) begin
        q[0] <= din;
        for (int unsigned i = 1; i < LAT; i++) begin
          q[i] <= q[i-1];
        end
      end
      if (clr) begin
        for (int unsigned i = 0; i < LAT; i++) begin
          q[i].valid <= 1'b0;
        end
      end
    end
  end

  assign tail = q[LAT-1];

endmodule

// File: rtl/vfpu_spec_merge.sv
// FMA lane tail: merges special-case results with the datapath result behind a valid/ready
// output register. Optional feature macro: VFPU_EXC_FLAGS_EN (sticky IEEE flags, flag_clr/flags ports).
module vfpu_spec_merge
  import vfpu_pkg::*;
#(
  parameter int unsigned LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              spec_mask,
  input  logic [RES_W-1:0]  res_spec,
  input  logic [KIND_W-1:0] spec_kind,
  output logic              pipe_adv,
  input  logic [RES_W-1:0]  dp_res,
  input  logic              dp_ovf,
  input  logic              dp_unf,
  input  logic              dp_inx,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_res
`ifdef VFPU_EXC_FLAGS_EN
  ,
  input  logic              flag_clr,
  output logic [FLAG_W-1:0] flags
`endif
);

  logic             adv;
  logic             load_c;
  logic [RES_W-1:0] res_sel_c;
  dline_entry_t     din;
  dline_entry_t     tail;

  // Whole lane moves whenever the output slot is empty or being drained
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;
  assign pipe_adv = adv;

  // Pack the handler decision into the head entry; flush drops a same-cycle issue
  always_comb begin
    din       = '0;
    din.valid = in_valid;
    din.mask  = spec_mask;
    din.res   = res_spec;
`ifdef VFPU_EXC_FLAGS_EN
    din.kind  = spec_kind_e'(spec_kind);
`endif
  end

  vfpu_spec_dline #(
    .LAT (LAT)
  ) u_dline (
    .clk  (clk),
    .rst  (rst),
    .en   (adv),
    .clr  (flush),
    .din  (din),
    .tail (tail)
  );

  assign load_c    = adv & tail.valid & ~flush;
  assign res_sel_c = tail.mask ? tail.res : dp_res;

  // Output register: takes the tail on advance, keeps its last result when the tail is empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_res   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= tail.valid;
      if (tail.valid) begin
        out_res <= res_sel_c;
      end
    end
  end

`ifdef VFPU_EXC_FLAGS_EN
  logic [FLAG_W-1:0] flag_add_c;

  // Special kinds only count when they actually overrode the datapath
  always_comb begin
    flag_add_c = '0;
    if (tail.mask) begin
      flag_add_c = kind_flags(tail.kind);
    end else begin
      flag_add_c[FLAG_OF] = dp_ovf;
      flag_add_c[FLAG_UF] = dp_unf;
      flag_add_c[FLAG_NX] = dp_inx;
    end
  end

  // Sticky flags: clear happens before the new contribution is ORed in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags <= '0;
    end else begin
      flags <= (flag_clr ? FLAG_W'(0) : flags) | (load_c ? flag_add_c : FLAG_W'(0));
    end
  end
`else
  logic unused_flag_inputs;
  assign unused_flag_inputs = ^{spec_kind, dp_ovf, dp_unf, dp_inx, load_c};
`endif

endmodule

// File: tb/tb_vfpu_spec_merge.sv
// Directed self-checking bench for vfpu_spec_merge (LAT=4), with a small datapath stand-in
// and an expected-result queue. Flag checks are built only with VFPU_EXC_FLAGS_EN.
module tb_vfpu_spec_merge;

  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        spec_mask;
  logic [31:0] res_spec;
  logic [2:0]  spec_kind;
  logic        pipe_adv;
  logic [31:0] dp_res;
  logic        dp_ovf, dp_unf, dp_inx;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_res;
`ifdef VFPU_EXC_FLAGS_EN
  logic        flag_clr;
  logic [4:0]  flags;
`endif

  // Bench-side datapath stimulus for the op being issued
  logic [31:0] dp_val_in;
  logic [2:0]  dp_flg_in;
  logic [31:0] dpv [LAT];
  logic [2:0]  dpf [LAT];

  int n_chk  = 0;
  int n_pass = 0;
  int rcvd   = 0;
  logic [31:0] exp_q [$];
  logic        stall_prev = 1'b0;
  logic [31:0] res_prev   = '0;

  vfpu_spec_merge #(.LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .spec_mask (spec_mask),
    .res_spec  (res_spec),
    .spec_kind (spec_kind),
    .pipe_adv  (pipe_adv),
    .dp_res    (dp_res),
    .dp_ovf    (dp_ovf),
    .dp_unf    (dp_unf),
    .dp_inx    (dp_inx),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res)
`ifdef VFPU_EXC_FLAGS_EN
    ,
    .flag_clr  (flag_clr),
    .flags     (flags)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Datapath stand-in: LAT stages that stall with pipe_adv
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        dpv[i] <= '0;
        dpf[i] <= '0;
      end
    end else if (pipe_adv) begin
      dpv[0] <= dp_val_in;
      dpf[0] <= dp_flg_in;
      for (int i = 1; i < LAT; i++) begin
        dpv[i] <= dpv[i-1];
        dpf[i] <= dpf[i-1];
      end
    end
  end
  assign dp_res = dpv[LAT-1];
  assign {dp_ovf, dp_unf, dp_inx} = dpf[LAT-1];

  // Scoreboard push on accepted issue; flush or reset kills everything in flight
  always @(posedge clk) begin
    if (rst || flush) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(spec_mask ? res_spec : dp_val_in);
  end

  // Output monitor away from the active edge
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("stall_hold", out_res, res_prev);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_valid", 32'(out_valid), 32'd0);
        else begin
          check("out_res", out_res, exp_q.pop_front());
          rcvd++;
        end
      end
      stall_prev = out_valid && !out_ready;
      res_prev   = out_res;
    end
  end

  task automatic issue(input logic m, input logic [31:0] r, input logic [2:0] k,
                       input logic [31:0] dv, input logic [2:0] df);
    logic acc;
    acc = 1'b0;
    spec_mask = m; res_spec = r; spec_kind = k; dp_val_in = dv; dp_flg_in = df;
    in_valid = 1'b1;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("issue_accepted", 32'(acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int g = 0; g < 60; g++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid) break;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

`ifdef VFPU_EXC_FLAGS_EN
  task automatic clear_flags();
    flag_clr = 1'b1;
    @(posedge clk);
    #1;
    flag_clr = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1; in_valid = 1'b0; spec_mask = 1'b0; res_spec = '0; spec_kind = '0;
    flush = 1'b0; out_ready = 1'b1; dp_val_in = '0; dp_flg_in = '0;
`ifdef VFPU_EXC_FLAGS_EN
    flag_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_res", out_res, 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_pipe_adv", 32'(pipe_adv), 32'd1);
`ifdef VFPU_EXC_FLAGS_EN
    check("rst_flags", 32'(flags), 32'd0);
`endif

    // Special invalid result: exact latency LAT+1
    issue(1'b1, 32'h7FC0_0000, 3'd2, 32'h1111_1111, 3'b000);
    repeat (LAT-1) @(posedge clk);
    #1 check("lat_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_res", out_res, 32'h7FC0_0000);
`ifdef VFPU_EXC_FLAGS_EN
    check("flags_invalid", 32'(flags), 32'h10);
`endif
    repeat (3) @(posedge clk);
    #1 check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_res_hold", out_res, 32'h7FC0_0000);

    // Datapath result; kind without mask is ignored
`ifdef VFPU_EXC_FLAGS_EN
    clear_flags();
`endif
    issue(1'b0, 32'h0, 3'd3, 32'h3F80_0000, 3'b001);
    drain();
    check("dp_res", out_res, 32'h3F80_0000);
`ifdef VFPU_EXC_FLAGS_EN
    check("flags_dp_inx", 32'(flags), 32'h02);
    clear_flags();
`endif

    // 8 back-to-back ops with a 3-cycle consumer stall
    base = rcvd;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          if (i % 2 == 0) issue(1'b1, 32'h4000_0000 + 32'(i), (i == 0) ? 3'd1 : 3'd0, 32'hDEAD_0000, 3'b000);
          else            issue(1'b0, 32'h0, 3'd0, 32'h3F80_0000 + 32'(i), 3'b000);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    check("b2b_count", 32'(rcvd - base), 32'd8);
`ifdef VFPU_EXC_FLAGS_EN
    check("flags_nan", 32'(flags), 32'h11);
`endif

    // Flush with 3 in flight and a same-cycle issue
    base = rcvd;
    for (int i = 0; i < 3; i++) issue(1'b1, 32'hAAAA_0000 + 32'(i), 3'd0, 32'h0, 3'b000);
    flush = 1'b1;
    issue(1'b1, 32'hBAD0_BAD0, 3'd0, 32'h0, 3'b000);
    flush = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 check("flush_no_valid", 32'(out_valid), 32'd0);
    end
    issue(1'b1, 32'h1234_5678, 3'd0, 32'h0, 3'b000);
    repeat (LAT-1) @(posedge clk);
    #1 check("post_flush_early", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 check("post_flush_valid", 32'(out_valid), 32'd1);
    check("post_flush_res", out_res, 32'h1234_5678);
    drain();
    check("flush_count", 32'(rcvd - base), 32'd1);

`ifdef VFPU_EXC_FLAGS_EN
    // Overflow load coincident with clear, then clear alone
    issue(1'b1, 32'h7F80_0000, 3'd3, 32'h0, 3'b000);
    repeat (LAT-1) @(posedge clk);
    #1 flag_clr = 1'b1;
    @(posedge clk);
    #1 flag_clr = 1'b0;
    check("flags_ovf_clr", 32'(flags), 32'h0A);
    check("ovf_res", out_res, 32'h7F80_0000);
    clear_flags();
    check("flags_clr_only", 32'(flags), 32'h00);
`endif

    // Reset mid-stream
    for (int i = 0; i < 6; i++) issue(1'b1, 32'hC000_0000 + 32'(i), 3'd2, 32'h0, 3'b000);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    exp_q.delete();
    #1 check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_res", out_res, 32'h0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
`ifdef VFPU_EXC_FLAGS_EN
    check("mid_rst_flags", 32'(flags), 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (LAT + 4) @(posedge clk);
    #1 check("post_rst_no_stale", 32'(out_valid), 32'd0);
    issue(1'b0, 32'h0, 3'd0, 32'h3F00_0000, 3'b000);
    drain();
    check("post_rst_res", out_res, 32'h3F00_0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vfpu_spec_merge.md
# vfpu_spec_merge

Downstream of the special-case handler in the vector FPU FMA lane (a×b+c). Carries the handler's per-operation `spec_mask`/`res_spec` decision down a delay line that moves in lockstep with the FMA datapath. At the datapath tail it selects the special result or the computed result. It registers the final result behind a valid/ready handshake and accumulates IEEE exception flags.

## Interface
- `LAT`, 4: FMA datapath depth in stages. Legal range 1..8. The delay line has exactly `LAT` entries.
- `clk` in 1: single clock. All state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operation issued this cycle. Its special-case decision is on the next three inputs.
- `in_ready` out 1: equals `adv`. Issue occurs only when `in_valid & in_ready`.
- `spec_mask` in 1: special-case handler overrides the datapath result.
- `res_spec` in 32: special-case result.
- `spec_kind` in 3: which special case applied.
  - 0 none, 1 NaN operand, 2 invalid, 3 overflow, 4 underflow/flush, 5 zero operand, 6 infinity operand.
  - 7 is reserved and treated as 0.
- `pipe_adv` out 1: stall/advance enable sent to the datapath. Equal to `adv`.
- `dp_res` in 32: datapath result aligned with tail entry `LAT-1`.
- `dp_ovf`, `dp_unf`, `dp_inx` in 1 each: datapath rounding flags, aligned the same way as `dp_res`.
- `flush` in 1: synchronous kill of all in-flight operations.
- `out_valid` out 1: final result is held.
- `out_ready` in 1: consumer accepts the held result.
- `out_res` out 32: final IEEE-754 single-precision result.
- `flag_clr` in 1: clears the sticky flags.
- `flags` out 5: sticky `{NV, OF, UF, NX, SN}`. Present only when `VFPU_EXC_FLAGS_EN` is defined.

## Operation
- `adv = ~out_valid | out_ready`.
- When `adv` is 1:
  - entry 0 loads `{in_valid, spec_mask, res_spec, spec_kind}`;
  - entry i loads entry i-1;
  - the output register loads from the tail entry.
- When `adv` is 0: all entries and the output register hold.
- Output register load:
  - `out_valid <= tail.valid`.
  - `out_res <= tail.mask ? tail.res : dp_res`.
  - If `tail.valid` is 0, `out_res` holds its old value.
- Flag contribution, applied only when a valid tail entry loads:
  - kind 1 sets SN and NV;
  - kind 2 sets NV;
  - kind 3 sets OF and NX;
  - kind 4 sets UF;
  - when `tail.mask` is 0, the `dp_ovf`/`dp_unf`/`dp_inx` bits OR into OF/UF/NX.
- Kind without mask: if `tail.mask` is 0, `tail.kind` is ignored and the datapath flags apply.
- Flush: clears every entry valid bit and `out_valid`. Data fields are untouched.
  - Flush beats `in_valid` in the same cycle; the issued operation is dropped.
  - `in_ready` is not gated by flush.
- Simultaneous `flag_clr` and a flag-setting load: the result is the new contribution only (clear first, then OR).
- Reset clears all valid bits, `out_valid`, `out_res` and `flags` to 0. Reset mid-operation discards everything in flight.

## Timing
- Reset values: `out_valid` 0, `out_res` 32'h0, `flags` 5'h0, `in_ready`/`pipe_adv` 1.
- Latency without stalls: an operation issued at cycle t appears with `out_valid` = 1 at cycle t+LAT+1.
- `in_ready` and `pipe_adv` are combinational from `out_valid`/`out_ready`. There is no path from `in_valid` to `in_ready`.
- Throughput is one operation per cycle while `out_ready` is held at 1.
- Stalls: while `out_valid & ~out_ready`, `out_res` is stable and no entry moves.
- Back-to-back issue must lose and duplicate nothing.

## Configuration
- `VFPU_EXC_FLAGS_EN` defined:
  - the sticky flag register, the `flags` port and the `flag_clr` port exist;
  - the delay line carries `spec_kind`.
- `VFPU_EXC_FLAGS_EN` undefined:
  - `flags` and `flag_clr` are absent;
  - `spec_kind` and `dp_ovf`/`dp_unf`/`dp_inx` are accepted but unused;
  - the delay line drops the kind field;
  - result and handshake behaviour are identical to the enabled build.

## Structure
- Shared package `vfpu_pkg`:
  - `spec_kind` encodings and width;
  - flag bit indices;
  - QNaN constant 32'h7FC0_0000;
  - the delay-line entry struct `{valid, mask, res, kind}`.
- One sub-module, `vfpu_spec_dline`:
  - a parameterised `LAT`-deep shift register with a shared enable and a synchronous valid-clear;
  - instantiated once.
- Top level holds `adv`, the result mux, the output register and the flag logic.

## Test plan
- LAT=4, issue `spec_mask`=1 with `res_spec`=32'h7FC0_0000 and kind 2 at t=0 → `out_res`=32'h7FC0_0000 at t=5; `flags`=5'b10000.
- Issue `spec_mask`=0 with `dp_res`=32'h3F80_0000 presented at the tail → `out_res`=32'h3F80_0000; with `dp_inx`=1, `flags`=5'b00010.
- Issue 8 back-to-back operations, drop `out_ready` for 3 cycles mid-stream → all 8 results arrive in order; `out_res` is stable during the stall; there are no duplicates.
- Assert `flush` on the same cycle as an issue while 3 operations are in flight → no `out_valid` for any of them; the next issue emerges after LAT+1 cycles.
- Kind 3 load coincident with `flag_clr` → `flags`=5'b01010. `flag_clr` alone → 5'b00000.
- Assert `rst` mid-stream → outputs immediately return to reset values; no stale result appears after release.
